// File: rtl/yari_pkg.sv
// yari_pkg: shared constants and types for the yari memory-port arbiter.
// Holds the master id encoding used on mem_id / mem_readdataid and the
// arbiter state encoding.
package yari_pkg;

  localparam logic [1:0] MEM_ID_NONE = 2'd0;
  localparam logic [1:0] MEM_ID_I    = 2'd1;
  localparam logic [1:0] MEM_ID_D    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/yari_outstanding_ctr.sv
// yari_outstanding_ctr: 4-bit count of accepted-but-unreturned reads for one
// master. full blocks further reads; zero marks a return as stray so the
// count never wraps below 0.
module yari_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

  logic [3:0] cnt;
  logic       dec_ok;

  assign dec_ok = dec && (cnt != 4'd0);
  assign full   = (cnt >= MAX_C);
  assign zero   = (cnt == 4'd0);

  // Count accepted reads up and valid returns down; a simultaneous pair cancels.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (inc && !dec_ok) begin
      cnt <= cnt + 4'd1;
    end else if (!inc && dec_ok) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/yari_mem_arbiter.sv
// yari_mem_arbiter: shares the single pipelined memory port between the fetch
// master (imem) and the load/store master (dmem). Requests are granted
// combinationally; a stalled grant is held in OWN_I/OWN_D until accepted.
// Returned words are routed by mem_readdataid, and each master is limited to
// MAX_OUTSTANDING reads in flight.
// Optional build macro: YARI_ARB_RR_EN -- round-robin tie break using the
// last accepted master (otherwise dmem always wins ties).
module yari_mem_arbiter
  import yari_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [29:0] imem_address,
  input  logic        imem_read,
  output logic        imem_waitrequest,
  output logic [31:0] imem_readdata,
  output logic        imem_readdatavalid,
  input  logic [29:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_writedata,
  input  logic [3:0]  dmem_writedatamask,
  output logic        dmem_waitrequest,
  output logic [31:0] dmem_readdata,
  output logic        dmem_readdatavalid,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic        err_stray
);

  arb_state_t state, state_next;
  logic full_i, full_d, zero_i, zero_d;
  logic elig_i, elig_d;
  logic grant_i, grant_d;
  logic acc_i, acc_d;
  logic ret_i, ret_d, ret_bad;

`ifdef YARI_ARB_RR_EN
  logic last_d;  // 1: dmem was the last master accepted, 0: imem
`endif

  assign elig_i = imem_read && !full_i;
  assign elig_d = dmem_write || (dmem_read && !full_d);

  // Pick the granted master; nothing is granted while reset is asserted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (elig_i && elig_d) begin
`ifdef YARI_ARB_RR_EN
            if (last_d) grant_i = 1'b1;
            else        grant_d = 1'b1;
`else
            grant_d = 1'b1;
`endif
          end else if (elig_i) begin
            grant_i = 1'b1;
          end else if (elig_d) begin
            grant_d = 1'b1;
          end
        end
        OWN_I:   grant_i = 1'b1;
        OWN_D:   grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign acc_i = grant_i && !mem_waitrequest;
  assign acc_d = grant_d && !mem_waitrequest;

  assign imem_waitrequest = !acc_i;
  assign dmem_waitrequest = !acc_d;

  assign mem_read          = (grant_i && imem_read) || (grant_d && dmem_read);
  assign mem_write         = grant_d && dmem_write;
  assign mem_id            = grant_i ? MEM_ID_I : (grant_d ? MEM_ID_D : MEM_ID_NONE);
  assign mem_address       = grant_i ? imem_address : (grant_d ? dmem_address : 30'd0);
  assign mem_writedata     = dmem_writedata;
  assign mem_writedatamask = grant_d ? dmem_writedatamask : 4'd0;

  // mem_readdataid==0 is the idle encoding of the return bus, not a return.
  assign ret_i   = rst_n && (mem_readdataid == MEM_ID_I);
  assign ret_d   = rst_n && (mem_readdataid == MEM_ID_D);
  assign ret_bad = (mem_readdataid == 2'd3) || (ret_i && zero_i) || (ret_d && zero_d);

  assign imem_readdata      = mem_readdata;
  assign dmem_readdata      = mem_readdata;
  assign imem_readdatavalid = ret_i;
  assign dmem_readdatavalid = ret_d;

  // Next state: a stalled grant from IDLE becomes ownership until accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i && mem_waitrequest)      state_next = OWN_I;
        else if (grant_d && mem_waitrequest) state_next = OWN_D;
      end
      OWN_I:   if (acc_i) state_next = IDLE;
      OWN_D:   if (acc_d) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register arbiter state and the sticky stray-return flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err_stray <= 1'b0;
    end else begin
      state <= state_next;
      if (ret_bad) err_stray <= 1'b1;
    end
  end

`ifdef YARI_ARB_RR_EN
  // Remember which master was accepted last for the round-robin tie break.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (acc_i) begin
      last_d <= 1'b0;
    end else if (acc_d) begin
      last_d <= 1'b1;
    end
  end
`endif

  yari_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr_i (
    .clock (clock),
    .rst_n (rst_n),
    .inc   (acc_i && imem_read),
    .dec   (ret_i),
    .full  (full_i),
    .zero  (zero_i)
  );

  yari_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr_d (
    .clock (clock),
    .rst_n (rst_n),
    .inc   (acc_d && dmem_read),
    .dec   (ret_d),
    .full  (full_d),
    .zero  (zero_d)
  );

endmodule
